bit_serializer: RTL and testbench

Parallel-to-serial front end that produces the single-bit stream consumed by the pattern-detecting FSM downstream (drives its x input). It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per DIV clock cycles. It supports back-to-back frames, so the stream has no idle gaps and cross-word patterns stay intact.

---
 rtl/bit_serializer.sv | 161 ++++++++++++++++
 tb/tb_bit_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial front end. Shifts a WIDTH-bit word out on x_out,
//            one bit per DIV clocks, back-to-back frames without gaps.
//            Optional macro SER_PARITY_EN appends an even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_strobe,
    output logic             busy,
    output logic             frame_done
);

`ifdef SER_PARITY_EN
    localparam int C_NBITS = WIDTH + 1;
`else
    localparam int C_NBITS = WIDTH;
`endif
    localparam int C_DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int C_BCW = (C_NBITS > 1) ? $clog2(C_NBITS) : 1;
    localparam logic [C_DCW-1:0] C_DIV_LAST = C_DCW'(DIV - 1);
    localparam logic [C_BCW-1:0] C_BIT_LAST = C_BCW'(C_NBITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [C_DCW-1:0]   div_cnt_q, div_cnt_d;
    logic [C_BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic               x_out_q, x_out_d;
    logic               x_strobe_q, x_strobe_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
`ifdef SER_PARITY_EN
    localparam logic [C_BCW-1:0] C_BIT_DATA_LAST = C_BCW'(WIDTH - 1);
    logic               parity_q, parity_d;
`endif

    logic               w_accept;
    logic               w_first_bit;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_load_rest;
    logic [WIDTH-1:0]   w_shreg_adv;

    // shreg holds the bits still to be sent, next one at the outgoing end
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_first_bit = load_data[WIDTH-1];
            assign w_load_rest = {load_data[WIDTH-2:0], 1'b0};
            assign w_next_bit  = shreg_q[WIDTH-1];
            assign w_shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit = load_data[0];
            assign w_load_rest = {1'b0, load_data[WIDTH-1:1]};
            assign w_next_bit  = shreg_q[0];
            assign w_shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign load_ready = (state_q == ST_IDLE) | frame_done_q;
    assign w_accept   = load_valid & load_ready;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        x_out_d    = x_out_q;
        x_strobe_d = 1'b0;
        busy_d     = busy_q;
`ifdef SER_PARITY_EN
        parity_d   = parity_q;
`endif
        if (w_accept) begin
            state_d    = ST_SHIFT;
            busy_d     = 1'b1;
            x_out_d    = w_first_bit;
            x_strobe_d = 1'b1;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            shreg_d    = w_load_rest;
`ifdef SER_PARITY_EN
            parity_d   = ^load_data;
`endif
        end else if (state_q == ST_SHIFT) begin
            if (div_cnt_q == C_DIV_LAST) begin
                div_cnt_d = '0;
                if (bit_cnt_q == C_BIT_LAST) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    x_out_d   = 1'b0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    x_strobe_d = 1'b1;
                    shreg_d    = w_shreg_adv;
`ifdef SER_PARITY_EN
                    x_out_d    = (bit_cnt_q == C_BIT_DATA_LAST) ? parity_q : w_next_bit;
`else
                    x_out_d    = w_next_bit;
`endif
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
        // Registered pulse: high in the cycle that will hold the last bit's final count
        frame_done_d = (state_d == ST_SHIFT) && (div_cnt_d == C_DIV_LAST) &&
                       (bit_cnt_d == C_BIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            x_out_q      <= 1'b0;
            x_strobe_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            x_out_q      <= x_out_d;
            x_strobe_q   <= x_strobe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign x_out      = x_out_q;
    assign x_strobe   = x_strobe_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Self-checking bench for bit_serializer (MSB-first DIV=4 instance
//            with a bit scoreboard, plus an LSB-first DIV=1 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef SER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int FD = NB * DIV;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready, x_out, x_strobe, busy, frame_done;
    logic [WIDTH-1:0] d1;
    logic             v1;
    logic             r1, x1, s1, b1, fd1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic q[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH), .DIV(DIV), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .x_out(x_out), .x_strobe(x_strobe),
        .busy(busy), .frame_done(frame_done)
    );

    bit_serializer #(.WIDTH(WIDTH), .DIV(1), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .load_data(d1), .load_valid(v1),
        .load_ready(r1), .x_out(x1), .x_strobe(s1),
        .busy(b1), .frame_done(fd1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) q.push_back(w[WIDTH-1-i]);
`ifdef SER_PARITY_EN
        q.push_back(^w);
`endif
    endtask

    // Scoreboard monitor for the MSB-first instance
    logic last_bit  = 1'b0;
    logic prev_busy = 1'b0;
    int   gap       = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            gap       = 0;
        end else begin
            if (x_strobe) begin
                check_val("strobe_busy", busy, 1);
                if (q.size() == 0) begin
                    check_val("sb_empty", 1, 0);
                end else begin
                    check_val("sb_bit", x_out, q.pop_front());
                end
                if (prev_busy) check_val("strobe_gap", gap, DIV);
                gap      = 1;
                last_bit = x_out;
            end else if (busy) begin
                gap++;
                check_val("bit_hold", x_out, last_bit);
            end else begin
                check_val("idle_x_out", x_out, 0);
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic [WIDTH-1:0] w1;
        rst = 1'b1; load_valid = 1'b0; load_data = '0; v1 = 1'b0; d1 = '0;
        repeat (3) tick();
        check_val("rst_x_out", x_out, 0);
        check_val("rst_strobe", x_strobe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", frame_done, 0);
        check_val("rst_ready", load_ready, 1);
        check_val("rst_busy_lsb", b1, 0);
        // reset wins over a simultaneous load
        load_valid = 1'b1; load_data = 8'hFF;
        tick();
        check_val("rst_vs_load", busy, 0);
        load_valid = 1'b0;
        rst = 1'b0;
        tick();

        // single frame, with an ignored load mid-frame
        load_data = 8'hB0; load_valid = 1'b1; push_word(8'hB0);
        cyc = 0; tick();
        load_valid = 1'b0;
        check_val("f1_busy", busy, 1);
        check_val("f1_first", x_out, 1);
        check_val("f1_ready", load_ready, 0);
        while (cyc < 10) tick();
        load_data = 8'hFF; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        while (cyc < FD - 1) tick();
        check_val("f1_done_early", frame_done, 0);
        tick();
        check_val("f1_done", frame_done, 1);
        check_val("f1_done_ready", load_ready, 1);
        tick();
        check_val("f1_idle_busy", busy, 0);
        check_val("f1_idle_x", x_out, 0);
        check_val("f1_idle_done", frame_done, 0);
        check_val("f1_idle_strobe", x_strobe, 0);
        tick();

        // back-to-back frames with load_valid held high
        load_data = 8'hB0; load_valid = 1'b1; push_word(8'hB0);
        cyc = 0; tick();
        load_data = 8'h58; push_word(8'h58);
        while (cyc < FD) begin
            check_val("b2b_ready", load_ready, 0);
            tick();
        end
        check_val("b2b_ready_done", load_ready, 1);
        check_val("b2b_done1", frame_done, 1);
        tick();
        load_valid = 1'b0;
        check_val("b2b_busy", busy, 1);
        check_val("b2b_strobe", x_strobe, 1);
        check_val("b2b_bit0", x_out, 0);
        while (cyc < 2 * FD) tick();
        check_val("b2b_done2", frame_done, 1);
        tick();
        check_val("b2b_idle", busy, 0);
        tick();

        // reset mid-frame
        load_data = 8'hA5; load_valid = 1'b1; push_word(8'hA5);
        cyc = 0; tick();
        load_valid = 1'b0;
        while (cyc < 12) tick();
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        check_val("abort_x", x_out, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_ready", load_ready, 1);
        check_val("abort_done", frame_done, 0);
        repeat (FD) begin
            tick();
            check_val("abort_no_done", frame_done, 0);
        end

        // LSB-first, DIV=1 instance
        w1 = 8'h0D;
        d1 = w1; v1 = 1'b1;
        cyc = 0; tick();
        v1 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check_val("lsb_bit", x1, (i < WIDTH) ? w1[i] : ^w1);
            check_val("lsb_strobe", s1, 1);
            check_val("lsb_busy", b1, 1);
            check_val("lsb_done", fd1, (i == NB - 1) ? 1 : 0);
            tick();
        end
        check_val("lsb_idle", b1, 0);
        check_val("lsb_idle_x", x1, 0);

        check_val("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
